wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Architectural state sink at the far end of the write-back stage of the 5-stage MIPS core.
- Consumes the WB-stage write bundle: GPR write plus HI/LO write.
- Holds the 32x32 general-purpose register file and the HI/LO register pair.
- Serves two combinational GPR read ports and the HI/LO read values to the decode/execute stages, with same-cycle write-through bypass.

Parameters:
- DATA_W, 32, width of GPRs, HI and LO
- ADDR_W, 5, GPR address width
- NUM_REGS, 32, number of GPRs; must equal 2**ADDR_W

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- wb_wreg  input  1  GPR write enable from WB stage
- wb_wd  input  ADDR_W  GPR write address
- wb_wdata  input  DATA_W  GPR write data
- wb_whilo  input  1  HI/LO write enable from WB stage
- wb_hi  input  DATA_W  HI write data
- wb_lo  input  DATA_W  LO write data
- re1  input  1  read enable, port 1
- raddr1  input  ADDR_W  read address, port 1
- rdata1  output  DATA_W  read data, port 1
- re2  input  1  read enable, port 2
- raddr2  input  ADDR_W  read address, port 2
- rdata2  output  DATA_W  read data, port 2
- hi_o  output  DATA_W  current HI (bypassed)
- lo_o  output  DATA_W  current LO (bypassed)

Behaviour:
- Reset: asynchronous, active-high (rst=1 acts immediately, independent of clk).
  - All GPRs, HI and LO cleared to 0.
  - While rst=1, rdata1, rdata2, hi_o and lo_o are forced to 0, and writes are ignored.
  - Reset asserted mid-operation discards any write presented in that cycle.
- GPR write: on posedge clk with rst=0, wb_wreg=1 and wb_wd!=0, regs[wb_wd] <= wb_wdata. Write latency is 1 edge.
- Register $0 is hardwired to 0. Writes to address 0 are silently dropped and never bypassed.
- GPR read (combinational, no latency), evaluated per port in this priority order:
  1. rst=1 -> 0
  2. raddrN==0 -> 0
  3. reN=0 -> 0
  4. wb_wreg=1 and wb_wd==raddrN -> wb_wdata (write-through bypass; same-cycle RAW resolved)
  5. otherwise -> regs[raddrN]
- Both ports may read the same address, including the address being written; each gets the bypassed value independently.
- HI/LO write: on posedge clk with rst=0 and wb_whilo=1, HI <= wb_hi and LO <= wb_lo together. There are no separate HI-only or LO-only writes; the WB stage supplies the unchanged half.
- HI/LO read (combinational):
  - rst=1 -> 0
  - wb_whilo=1 -> wb_hi / wb_lo (bypass)
  - otherwise -> stored HI / LO
- Simultaneous GPR write and HI/LO write in the same cycle are independent and both take effect.
- No stall or flush inputs; gating is the upstream mem_wb register's job. A bubble arrives as wb_wreg=0, wb_whilo=0.
- No X propagation: all outputs are defined in every cycle after reset.

Decomposition:
- Shared constants stay in the core's existing define header:
  - RstEnable, WriteEnable/WriteDisable, ReadEnable/ReadDisable
  - ZeroWord, NOPRegAddr
  - RegBus, RegAddrBus, RegNum
- Nothing new is added to the header.
- One natural sub-module: wb_hilo_reg, holding the HI/LO pair, its write logic and bypass muxes. The GPR array and read ports stay in wb_regfile.

Test Plan:
- Reset check: assert rst mid-cycle with regs preloaded -> all outputs 0 immediately. After release, read $1..$31 -> 0; hi_o=lo_o=0.
- Write then read: write $5=0xDEADBEEF at edge N. At N+1 read raddr1=5, re1=1 -> rdata1=0xDEADBEEF. With re1=0 -> 0.
- $0 protection: wb_wreg=1, wb_wd=0, wb_wdata=0x12345678, raddr1=0 -> rdata1=0 during and after the edge.
- Bypass: $7 holds 0x11111111; present write $7=0x22222222 with raddr1=raddr2=7 in the same cycle -> both ports 0x22222222 before the edge and after.
- HI/LO: wb_whilo=1, hi=0x0000ABCD, lo=0x89ABCDEF -> hi_o/lo_o show these in the same cycle and hold them after wb_whilo drops. A concurrent GPR write to $3=0x5 also lands.
- Reset during write: rst rises while wb_wreg=1 for $9=0xFFFFFFFF -> $9 reads 0 after rst is released.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared constants and helpers for the write-back register file slice.
//   - default widths for the GPR file and HI/LO pair
//   - enable-level constants used by the write and read paths
//   - rd_src_e / rd_src_sel(): per-port read-source priority decode
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 32;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

    // Where a GPR read port takes its value from in the current cycle.
    typedef enum logic [2:0] {
        SRC_RESET    = 3'd0,
        SRC_ZERO_REG = 3'd1,
        SRC_DISABLED = 3'd2,
        SRC_BYPASS   = 3'd3,
        SRC_ARRAY    = 3'd4
    } rd_src_e;

    // Priority: reset, then $0, then read disable, then write-through bypass,
    // and only then the stored array value. $0 sits above the bypass so a
    // write aimed at $0 can never leak onto a read port.
    function automatic rd_src_e rd_src_sel(
        input logic in_rst,
        input logic addr_zero,
        input logic rd_en,
        input logic wr_hit
    );
        if (in_rst)         return SRC_RESET;
        else if (addr_zero) return SRC_ZERO_REG;
        else if (!rd_en)    return SRC_DISABLED;
        else if (wr_hit)    return SRC_BYPASS;
        else                return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
//   Bundle between the WB stage / decode-execute consumers and the register
//   file.
//   master: drives the WB write bundle and read requests, receives read data
//   slave : the register file itself
//   Signals:
//     wb_wreg, wb_wd, wb_wdata   GPR write enable / address / data
//     wb_whilo, wb_hi, wb_lo     HI/LO joint write enable and data
//     re1, raddr1, rdata1        read port 1
//     re2, raddr2, rdata2        read port 2
//     hi_o, lo_o                 current (bypassed) HI / LO
// ---------------------------------------------------------------------------
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_wreg;
    logic [ADDR_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o
    );
endinterface

// File: rtl/wb_hilo_reg.sv
// ---------------------------------------------------------------------------
// wb_hilo_reg
//   HI/LO register pair with joint write and same-cycle bypass.
//   Ports:
//     clk, rst        core clock, async active-high reset
//     whilo           joint HI/LO write enable
//     hi_in, lo_in    write data (WB stage supplies the unchanged half)
//     hi_o, lo_o      current HI / LO, forced to 0 during reset
// ---------------------------------------------------------------------------
module wb_hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (whilo == WRITE_ENABLE) begin
            hi_q <= hi_in;
            lo_q <= lo_in;
        end
    end

    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst == RST_ENABLE) begin
            hi_o = '0;
            lo_o = '0;
        end else if (whilo == WRITE_ENABLE) begin
            hi_o = hi_in;
            lo_o = lo_in;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Architectural state at the end of write-back: 32x32 GPR file with two
//   combinational read ports plus the HI/LO pair (in wb_hilo_reg).
//   Ports:
//     clk, rst   core clock, async active-high reset (clears all state,
//                forces all read outputs to 0 while asserted)
//     bus        wb_regfile_if.slave: WB write bundle, read ports, HI/LO out
//   $0 is never written and always reads 0. A write presented in the same
//   cycle as a read of the same address is forwarded to the read port.
// ---------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    generate
        if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
            $error("wb_regfile: NUM_REGS must equal 2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic    wr_active;
    rd_src_e src1;
    rd_src_e src2;

    // A write to $0 is dropped here, and the same qualifier keeps it out of
    // the bypass path, so $0 stays zero in the array and on the read ports.
    assign wr_active = (bus.wb_wreg == WRITE_ENABLE) && (bus.wb_wd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[bus.wb_wd] <= bus.wb_wdata;
        end
    end

    assign src1 = rd_src_sel(rst == RST_ENABLE,
                             bus.raddr1 == '0,
                             bus.re1 == READ_ENABLE,
                             wr_active && (bus.wb_wd == bus.raddr1));

    assign src2 = rd_src_sel(rst == RST_ENABLE,
                             bus.raddr2 == '0,
                             bus.re2 == READ_ENABLE,
                             wr_active && (bus.wb_wd == bus.raddr2));

    always_comb begin
        bus.rdata1 = '0;
        case (src1)
            SRC_BYPASS: bus.rdata1 = bus.wb_wdata;
            SRC_ARRAY:  bus.rdata1 = regs[bus.raddr1];
            default:    bus.rdata1 = '0;
        endcase
    end

    always_comb begin
        bus.rdata2 = '0;
        case (src2)
            SRC_BYPASS: bus.rdata2 = bus.wb_wdata;
            SRC_ARRAY:  bus.rdata2 = regs[bus.raddr2];
            default:    bus.rdata2 = '0;
        endcase
    end

    wb_hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk   (clk),
        .rst   (rst),
        .whilo (bus.wb_whilo),
        .hi_in (bus.wb_hi),
        .lo_in (bus.wb_lo),
        .hi_o  (bus.hi_o),
        .lo_o  (bus.lo_o)
    );

endmodule
